// File: rtl/mem_req_gen.sv
// mem_req_gen: clocked line-fill request generator with req/ready handshake, address modes, request limit and timeout.
// Ports: clk/rst (sync, active-high); enable, mode, base_addr, num_req control a run;
// mem_req/mem_addr/mem_ready/mem_data form the memory handshake; rsp_valid/rsp_addr/rsp_data
// present each captured line for one cycle; req_count, done and timeout_err report progress.
// Optional MEM_REQ_GEN_STATS_EN adds live latency counters on lat_max/lat_sum (tied to 0 otherwise).
module mem_req_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int REQ_PERIOD = 10,
  parameter int TIMEOUT = 64,
  parameter int STRIDE = 4,
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_req,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [15:0]           req_count,
  output logic                  done,
  output logic                  timeout_err,
  output logic [15:0]           lat_max,
  output logic [31:0]           lat_sum
);
  localparam int LB = DATA_WIDTH / 8;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(REQ_PERIOD);
  localparam logic [ADDR_WIDTH-1:0] LINE = ADDR_WIDTH'(LB);
  localparam logic [ADDR_WIDTH-1:0] SSTEP = ADDR_WIDTH'(STRIDE * LB);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(LB - 1);
  localparam logic [31:0] POLY = 32'h8020_0003;
  typedef enum logic [2:0] {IDLE, REQ, GAP, DONE, ERR} state_e;
  state_e state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rsp_addr_q, rsp_addr_d, rnd_addr, adv_addr;
  logic [31:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic rsp_valid_q, rsp_valid_d, done_q, done_d, terr_q, terr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [15:0] cnt_q, cnt_d, cnt_new;
  logic start, fire, hit;
  assign lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
  assign rnd_addr = lfsr_nxt[ADDR_WIDTH-1:0] & AMASK;
  assign adv_addr = mode_q == 2'd0 ? rnd_addr :
                    mode_q == 2'd1 ? addr_q + LINE :
                    mode_q == 2'd2 ? addr_q + SSTEP : addr_q;
  assign start = state_q == IDLE && enable;
  assign fire = state_q == REQ && mem_ready;
  assign cnt_new = cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
  assign hit = num_req != 16'd0 && cnt_new == num_req;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    addr_d = addr_q;
    lfsr_d = lfsr_q;
    wcnt_d = wcnt_q;
    gcnt_d = gcnt_q;
    cnt_d = cnt_q;
    done_d = done_q;
    terr_d = terr_q;
    rsp_valid_d = fire;
    rsp_addr_d = fire ? addr_q : rsp_addr_q;
    rsp_data_d = fire ? mem_data : rsp_data_q;
    case (state_q)
      IDLE: if (enable) begin
        state_d = REQ;
        mode_d = mode;
        addr_d = mode == 2'd0 ? rnd_addr : base_addr & AMASK;
        lfsr_d = mode == 2'd0 ? lfsr_nxt : lfsr_q;
        wcnt_d = '0;
        cnt_d = '0;
        done_d = 1'b0;
      end
      REQ: if (mem_ready) begin
        cnt_d = cnt_new;
        done_d = hit;
        gcnt_d = '0;
        state_d = hit ? DONE : !enable ? IDLE : GAP;
      end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
        state_d = ERR;
        terr_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
      GAP: if (gcnt_q == GW'(REQ_PERIOD - 2)) begin
        // The LFSR only advances when a request is actually going to be issued.
        state_d = enable ? REQ : IDLE;
        addr_d = enable ? adv_addr : addr_q;
        lfsr_d = enable && mode_q == 2'd0 ? lfsr_nxt : lfsr_q;
        wcnt_d = '0;
      end else begin
        gcnt_d = gcnt_q + 1'b1;
      end
      DONE: state_d = enable ? DONE : IDLE;
      default: state_d = ERR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= '0;
      addr_q <= '0;
      lfsr_q <= SEED;
      wcnt_q <= '0;
      gcnt_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      terr_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      addr_q <= addr_d;
      lfsr_q <= lfsr_d;
      wcnt_q <= wcnt_d;
      gcnt_q <= gcnt_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      terr_q <= terr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  assign mem_req = state_q == REQ;
  assign mem_addr = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr = rsp_addr_q;
  assign rsp_data = rsp_data_q;
  assign req_count = cnt_q;
  assign done = done_q;
  assign timeout_err = terr_q;
`ifdef MEM_REQ_GEN_STATS_EN
  logic [15:0] lat_max_q, lat_max_d, lat16;
  logic [31:0] lat_sum_q, lat_sum_d, lat32;
  logic [32:0] sum33;
  always_comb begin
    // wcnt_q holds cycles waited so far; the completing cycle itself counts too.
    lat32 = 32'(wcnt_q) + 32'd1;
    lat16 = lat32 > 32'h0000_FFFF ? 16'hFFFF : lat32[15:0];
    sum33 = {1'b0, lat_sum_q} + {1'b0, lat32};
    lat_max_d = start ? '0 : fire && lat16 > lat_max_q ? lat16 : lat_max_q;
    lat_sum_d = start ? '0 : fire ? (sum33[32] ? '1 : sum33[31:0]) : lat_sum_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_max_q <= '0;
      lat_sum_q <= '0;
    end else begin
      lat_max_q <= lat_max_d;
      lat_sum_q <= lat_sum_d;
    end
  end
  assign lat_max = lat_max_q;
  assign lat_sum = lat_sum_q;
`else
  assign lat_max = '0;
  assign lat_sum = '0;
`endif
endmodule
